obi_rr_arbiter_outstanding: RTL and testbench

// - Round-robin arbiter sharing one OBI slave port between NMASTER OBI masters.
// - Tracks which master owns each outstanding transaction in an in-order ID FIFO.
// - Returns rvalid only to the owning master; limits in-flight transactions to MaxOutstanding.
// - Sits in front of a single-slave bus segment. MaxOutstanding=1 gives the "block until rvalid" rule.

---
 rtl/obi_rr_arbiter_outstanding.sv | 182 ++++++++++++++++++
 tb/tb_obi_rr_arbiter_outstanding.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter_outstanding.sv
// Round-robin OBI arbiter: NMASTER masters share one slave port.
// An in-order owner FIFO routes each rvalid back to the master that issued
// the transaction and caps in-flight transactions at MaxOutstanding.

package obi_rr_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_rr_arbiter_outstanding
  import obi_rr_pkg::*;
#(
  parameter int NMASTER        = 2,
  parameter int MaxOutstanding = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t  [NMASTER-1:0]              master_req_i,
  output obi_resp_t [NMASTER-1:0]              master_resp_o,
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_cnt_o,
  output logic                                 spurious_rvalid_o
);

  localparam int IdxW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Arbitration state
  logic [IdxW-1:0] rr_ptr;
  logic            lock;
  logic [IdxW-1:0] lock_idx;

  // Owner FIFO: one master index per granted-but-unanswered transaction
  logic [IdxW-1:0] fifo_mem [MaxOutstanding];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] cnt;

  // Combinational decisions
  logic            arb_en;
  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] head_idx;
  logic            hs;
  logic            pop;

  // FIFO pointers wrap at MaxOutstanding, which need not be a power of two
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next master after the one just served, wrapping to 0
  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NMASTER - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  assign arb_en   = (cnt < CntW'(MaxOutstanding));
  assign head_idx = fifo_mem[rptr];
  assign hs       = win_vld & slave_resp_i.gnt;
  // cnt is held at 0 during reset, so pop cannot fire then
  assign pop      = slave_resp_i.rvalid & (cnt != '0);

  // Pick the winner: locked master first, else round-robin scan from rr_ptr
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (lock) begin
      win_vld = 1'b1;
      win_idx = lock_idx;
    end else if (arb_en) begin
      // Upper part of the ring: rr_ptr .. NMASTER-1
      for (int i = 0; i < NMASTER; i++) begin
        if (!win_vld && (i >= int'(rr_ptr)) && master_req_i[i].req) begin
          win_vld = 1'b1;
          win_idx = IdxW'(i);
        end
      end
      // Wrapped part of the ring: 0 .. rr_ptr-1
      for (int i = 0; i < NMASTER; i++) begin
        if (!win_vld && (i < int'(rr_ptr)) && master_req_i[i].req) begin
          win_vld = 1'b1;
          win_idx = IdxW'(i);
        end
      end
    end
    // Nothing reaches the slave while reset is asserted
    if (!rst_ni) begin
      win_vld = 1'b0;
    end
  end

  // Forward the winner's request to the slave; zero when idle
  always_comb begin
    slave_req_o = '0;
    if (win_vld) begin
      slave_req_o     = master_req_i[win_idx];
      slave_req_o.req = 1'b1;
    end
  end

  // Route gnt to the winner, rvalid to the FIFO head, rdata to everyone
  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i].rdata  = slave_resp_i.rdata;
      master_resp_o[i].gnt    = win_vld & slave_resp_i.gnt & (win_idx == IdxW'(i));
      master_resp_o[i].rvalid = pop & (head_idx == IdxW'(i));
    end
  end

  assign outstanding_cnt_o = cnt;
  assign spurious_rvalid_o = rst_ni & slave_resp_i.rvalid & (cnt == '0);

  // Round-robin pointer and lock: advance on handshake, hold a stalled winner
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (win_vld) begin
      if (slave_resp_i.gnt) begin
        rr_ptr <= rr_next(win_idx);
        lock   <= 1'b0;
      end else begin
        lock     <= 1'b1;
        lock_idx <= win_idx;
      end
    end
  end

  // FIFO pointers and occupancy; push on handshake, pop on routed rvalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (hs) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      case ({hs, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Owner storage; contents are only meaningful below cnt, so no reset
  always_ff @(posedge clk_i) begin
    if (hs) begin
      fifo_mem[wptr] <= win_idx;
    end
  end

`ifndef SYNTHESIS
  // A held request never coexists with a full FIFO
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(lock && (cnt == CntW'(MaxOutstanding))));
  // Occupancy never exceeds the FIFO depth
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   cnt <= CntW'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_obi_rr_arbiter_outstanding.sv
// Bench for obi_rr_arbiter_outstanding: three instances (N=2/MO=1, N=3/MO=1,
// N=2/MO=2) driven by directed vectors, checked every cycle against a
// transaction-level model and at key points against literal expectations.

module tb_obi_rr_arbiter_outstanding;
  import obi_rr_pkg::*;

  logic clk;
  logic rst_ni;

  obi_req_t  [1:0] mreq0;
  obi_resp_t [1:0] mresp0;
  obi_req_t        sreq0;
  obi_resp_t       sresp0;
  logic [0:0]      cnt0;
  logic            spur0;

  obi_req_t  [2:0] mreq1;
  obi_resp_t [2:0] mresp1;
  obi_req_t        sreq1;
  obi_resp_t       sresp1;
  logic [0:0]      cnt1;
  logic            spur1;

  obi_req_t  [1:0] mreq2;
  obi_resp_t [1:0] mresp2;
  obi_req_t        sreq2;
  obi_resp_t       sresp2;
  logic [1:0]      cnt2;
  logic            spur2;

  int checks = 0;
  int errors = 0;

  // Model state per instance: rr pointer, held winner, ordered owner list
  int m_rr  [3];
  int m_lk  [3];
  int m_lki [3];
  int m_cnt [3];
  int m_own [3][4];

  int glog1[$];
  int rlog1[$];

  obi_rr_arbiter_outstanding #(.NMASTER(2), .MaxOutstanding(1)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .master_req_i(mreq0), .master_resp_o(mresp0),
    .slave_req_o(sreq0), .slave_resp_i(sresp0), .outstanding_cnt_o(cnt0),
    .spurious_rvalid_o(spur0));

  obi_rr_arbiter_outstanding #(.NMASTER(3), .MaxOutstanding(1)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .master_req_i(mreq1), .master_resp_o(mresp1),
    .slave_req_o(sreq1), .slave_resp_i(sresp1), .outstanding_cnt_o(cnt1),
    .spurious_rvalid_o(spur1));

  obi_rr_arbiter_outstanding #(.NMASTER(2), .MaxOutstanding(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .master_req_i(mreq2), .master_resp_o(mresp2),
    .slave_req_o(sreq2), .slave_resp_i(sresp2), .outstanding_cnt_o(cnt2),
    .spurious_rvalid_o(spur2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare one instance against the model for this cycle, then advance the model
  task automatic check_inst(input int i, input int n, input int mo,
                            input obi_req_t [2:0] mq, input obi_resp_t [2:0] mr,
                            input obi_req_t sq, input obi_resp_t sr,
                            input int cnt, input logic spur);
    int w;
    int head;
    bit do_pop;
    if (!rst_ni) begin
      chk($sformatf("u%0d.rst.req", i), sq.req, 0);
      chk($sformatf("u%0d.rst.cnt", i), cnt, 0);
      chk($sformatf("u%0d.rst.spur", i), spur, 0);
      for (int m = 0; m < n; m++) begin
        chk($sformatf("u%0d.rst.gnt%0d", i, m), mr[m].gnt, 0);
        chk($sformatf("u%0d.rst.rvalid%0d", i, m), mr[m].rvalid, 0);
      end
      m_rr[i] = 0; m_lk[i] = 0; m_lki[i] = 0; m_cnt[i] = 0;
      return;
    end
    w = -1;
    if (m_lk[i] != 0) begin
      w = m_lki[i];
    end else if (m_cnt[i] < mo) begin
      for (int k = 0; k < n; k++) begin
        int cand;
        cand = (m_rr[i] + k) % n;
        if (w < 0 && mq[cand].req) w = cand;
      end
    end
    head = m_own[i][0];
    do_pop = sr.rvalid && (m_cnt[i] > 0);
    chk($sformatf("u%0d.cnt", i), cnt, m_cnt[i]);
    chk($sformatf("u%0d.req", i), sq.req, (w >= 0));
    if (w >= 0) begin
      chk($sformatf("u%0d.fields", i), {sq.we, sq.be, sq.addr, sq.wdata},
          {mq[w].we, mq[w].be, mq[w].addr, mq[w].wdata});
    end else begin
      chk($sformatf("u%0d.fields", i), {sq.we, sq.be, sq.addr, sq.wdata}, 0);
    end
    chk($sformatf("u%0d.spur", i), spur, sr.rvalid && (m_cnt[i] == 0));
    for (int m = 0; m < n; m++) begin
      chk($sformatf("u%0d.gnt%0d", i, m), mr[m].gnt, (m == w) && sr.gnt);
      chk($sformatf("u%0d.rvalid%0d", i, m), mr[m].rvalid, do_pop && (m == head));
      chk($sformatf("u%0d.rdata%0d", i, m), mr[m].rdata, sr.rdata);
      if (i == 1 && mr[m].gnt) glog1.push_back(m);
      if (i == 1 && mr[m].rvalid) rlog1.push_back(m);
    end
    if (do_pop) begin
      for (int k = 0; k < 3; k++) m_own[i][k] = m_own[i][k+1];
      m_cnt[i]--;
    end
    if (w >= 0) begin
      if (sr.gnt) begin
        m_own[i][m_cnt[i]] = w;
        m_cnt[i]++;
        m_rr[i] = (w + 1) % n;
        m_lk[i] = 0;
      end else begin
        m_lk[i]  = 1;
        m_lki[i] = w;
      end
    end
  endtask

  // Per-cycle comparison of all three instances against the model
  always @(negedge clk) begin : cmp
    obi_req_t  [2:0] pq;
    obi_resp_t [2:0] pr;
    pq = '0; pr = '0; pq[1:0] = mreq0; pr[1:0] = mresp0;
    check_inst(0, 2, 1, pq, pr, sreq0, sresp0, int'(cnt0), spur0);
    check_inst(1, 3, 1, mreq1, mresp1, sreq1, sresp1, int'(cnt1), spur1);
    pq = '0; pr = '0; pq[1:0] = mreq2; pr[1:0] = mresp2;
    check_inst(2, 2, 2, pq, pr, sreq2, sresp2, int'(cnt2), spur2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mreq0 = '0; mreq1 = '0; mreq2 = '0;
    sresp0 = '0; sresp1 = '0; sresp2 = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      m_rr[i] = 0; m_lk[i] = 0; m_lki[i] = 0; m_cnt[i] = 0;
      for (int k = 0; k < 4; k++) m_own[i][k] = 0;
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // A: N=2 MO=1, both request, M0 first, M1 waits for M0's rvalid
    mreq0[0].req = 1; mreq0[0].addr = 32'h100; mreq0[0].we = 1; mreq0[0].be = 4'hF;
    mreq0[0].wdata = 32'hA0;
    mreq0[1].req = 1; mreq0[1].addr = 32'h200; mreq0[1].be = 4'h3;
    sresp0.gnt = 1;
    #1;
    chk("A.c0.gnt0", mresp0[0].gnt, 1);
    chk("A.c0.gnt1", mresp0[1].gnt, 0);
    chk("A.c0.addr", sreq0.addr, 32'h100);
    tick(); mreq0[0].req = 0; #1;
    chk("A.c1.cnt", cnt0, 1);
    chk("A.c1.req", sreq0.req, 0);
    chk("A.c1.gnt1", mresp0[1].gnt, 0);
    tick(); sresp0.rvalid = 1; sresp0.rdata = 32'hDEAD0000; #1;
    chk("A.c2.rvalid0", mresp0[0].rvalid, 1);
    chk("A.c2.rvalid1", mresp0[1].rvalid, 0);
    chk("A.c2.req_full", sreq0.req, 0);
    chk("A.c2.rdata1", mresp0[1].rdata, 32'hDEAD0000);
    tick(); sresp0.rvalid = 0; #1;
    chk("A.c3.cnt", cnt0, 0);
    chk("A.c3.gnt1", mresp0[1].gnt, 1);
    chk("A.c3.addr", sreq0.addr, 32'h200);
    tick(); mreq0[1].req = 0; sresp0.rvalid = 1; #1;
    chk("A.c4.rvalid1", mresp0[1].rvalid, 1);
    chk("A.c4.rvalid0", mresp0[0].rvalid, 0);
    tick(); idle();

    // B: N=3 MO=1, all request, rvalid one cycle after each grant
    glog1 = {}; rlog1 = {};
    for (int k = 0; k < 3; k++) begin
      mreq1[k].req = 1; mreq1[k].addr = 32'h1000 + k;
    end
    sresp1.gnt = 1;
    for (int c = 0; c < 8; c++) begin
      sresp1.rvalid = c[0];
      sresp1.rdata  = c;
      tick();
    end
    idle();
    chk("B.ngrants", glog1.size(), 4);
    chk("B.g0", glog1[0], 0); chk("B.g1", glog1[1], 1);
    chk("B.g2", glog1[2], 2); chk("B.g3", glog1[3], 0);
    chk("B.nrvalid", rlog1.size(), 4);
    chk("B.r0", rlog1[0], 0); chk("B.r1", rlog1[1], 1); chk("B.r2", rlog1[2], 2);
    tick();

    // C: N=2 MO=1, M1 stalled by slave; M0 arrives but cannot steal the slot
    mreq0[1].req = 1; mreq0[1].addr = 32'h222; sresp0.gnt = 0; #1;
    chk("C.c0.addr", sreq0.addr, 32'h222);
    chk("C.c0.req", sreq0.req, 1);
    for (int c = 1; c < 3; c++) begin
      tick();
      if (c == 1) begin
        mreq0[0].req = 1; mreq0[0].addr = 32'h111;
      end
      #1;
      chk($sformatf("C.c%0d.addr", c), sreq0.addr, 32'h222);
      chk($sformatf("C.c%0d.gnt0", c), mresp0[0].gnt, 0);
    end
    tick(); sresp0.gnt = 1; #1;
    chk("C.c3.addr", sreq0.addr, 32'h222);
    chk("C.c3.gnt1", mresp0[1].gnt, 1);
    chk("C.c3.gnt0", mresp0[0].gnt, 0);
    tick(); mreq0[1].req = 0; sresp0.gnt = 0; sresp0.rvalid = 1; #1;
    chk("C.c4.rvalid1", mresp0[1].rvalid, 1);
    tick(); idle(); tick();

    // D: N=2 MO=2, two back-to-back grants, full stall, ordered responses
    mreq2[0].req = 1; mreq2[0].addr = 32'h300;
    mreq2[1].req = 1; mreq2[1].addr = 32'h301;
    sresp2.gnt = 1; #1;
    chk("D.c0.gnt0", mresp2[0].gnt, 1);
    tick(); mreq2[0].req = 0; #1;
    chk("D.c1.gnt1", mresp2[1].gnt, 1);
    chk("D.c1.cnt", cnt2, 1);
    tick(); mreq2[1].req = 0; mreq2[0].req = 1; #1;
    chk("D.c2.cnt", cnt2, 2);
    chk("D.c2.req", sreq2.req, 0);
    chk("D.c2.gnt0", mresp2[0].gnt, 0);
    tick(); sresp2.rvalid = 1; #1;
    chk("D.c3.rvalid0", mresp2[0].rvalid, 1);
    chk("D.c3.rvalid1", mresp2[1].rvalid, 0);
    chk("D.c3.req", sreq2.req, 0);
    chk("D.c3.cnt", cnt2, 2);
    tick(); mreq2[0].req = 0; #1;
    chk("D.c4.rvalid1", mresp2[1].rvalid, 1);
    chk("D.c4.rvalid0", mresp2[0].rvalid, 0);
    chk("D.c4.cnt", cnt2, 1);
    tick(); sresp2.rvalid = 0; #1;
    chk("D.c5.cnt", cnt2, 0);
    mreq2[0].req = 1; #1;
    chk("D.c5.gnt0", mresp2[0].gnt, 1);
    tick(); mreq2[0].req = 0; mreq2[1].req = 1; sresp2.rvalid = 1; #1;
    chk("D.c6.rvalid0", mresp2[0].rvalid, 1);
    chk("D.c6.gnt1", mresp2[1].gnt, 1);
    tick(); mreq2[1].req = 0; #1;
    chk("D.c7.cnt_pushpop", cnt2, 1);
    chk("D.c7.rvalid1", mresp2[1].rvalid, 1);
    tick(); sresp2.rvalid = 0; #1;
    chk("D.c8.cnt", cnt2, 0);
    idle(); tick();

    // E: rvalid with nothing outstanding
    sresp0.rvalid = 1; #1;
    chk("E.spur", spur0, 1);
    chk("E.rvalid0", mresp0[0].rvalid, 0);
    chk("E.rvalid1", mresp0[1].rvalid, 0);
    chk("E.cnt", cnt0, 0);
    tick(); sresp0.rvalid = 0; #1;
    chk("E.spur_off", spur0, 0);
    chk("E.cnt_after", cnt0, 0);
    tick();

    // F: reset with one transaction in flight; late rvalid is spurious
    mreq0[0].req = 1; sresp0.gnt = 1;
    tick(); mreq0[0].req = 0; #1;
    chk("F.cnt1", cnt0, 1);
    rst_ni = 0; mreq0[1].req = 1; sresp0.rvalid = 1; #1;
    chk("F.rst.cnt", cnt0, 0);
    chk("F.rst.req", sreq0.req, 0);
    chk("F.rst.gnt1", mresp0[1].gnt, 0);
    chk("F.rst.rvalid0", mresp0[0].rvalid, 0);
    chk("F.rst.spur", spur0, 0);
    tick(); rst_ni = 1; mreq0[1].req = 0; sresp0.gnt = 0; #1;
    chk("F.late.spur", spur0, 1);
    chk("F.late.rvalid0", mresp0[0].rvalid, 0);
    chk("F.late.cnt", cnt0, 0);
    tick(); sresp0.rvalid = 0; mreq0[0].req = 1; mreq0[1].req = 1; sresp0.gnt = 1; #1;
    chk("F.rr.gnt0", mresp0[0].gnt, 1);
    chk("F.rr.gnt1", mresp0[1].gnt, 0);
    tick(); idle(); sresp0.rvalid = 1;
    tick(); idle();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
